// File: rtl/mvm_load_engine.sv
// rtl/mvm_load_engine.sv - fetches ROWS matrix words plus one vector word, then runs a
// COLS-cycle parallel multiply-accumulate into ROWS result registers.
module mvm_load_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ADDR_W     = 32,
  parameter int SIGNED     = 0,
  parameter int ACC_W      = 2*DATA_WIDTH + $clog2(COLS),
  parameter int WORD_W     = COLS*DATA_WIDTH,
  parameter int SEL_W      = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  input  logic [SEL_W-1:0]  res_sel,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic              proto_err
);

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(ROWS+1);
  localparam int KW    = $clog2(COLS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_COMPUTE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WORD_W-1:0]  a_q [ROWS];
  logic [WORD_W-1:0]  a_d [ROWS];
  logic [WORD_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0]   acc_q [ROWS];
  logic [ACC_W-1:0]   acc_d [ROWS];
  logic               proto_err_q, proto_err_d;
  logic [SEL_W-1:0]   row_idx;

  // Element 0 sits in the most significant slice of the word.
  function automatic logic [DW-1:0] elem(input logic [WORD_W-1:0] w, input logic [KW-1:0] k);
    return w[WORD_W-1-int'(k)*DW -: DW];
  endfunction

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    logic            ext;
    if (SIGNED != 0) p = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    else             p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    ext = (SIGNED != 0) ? p[2*DW-1] : 1'b0;
    return {{(ACC_W-2*DW){ext}}, p};
  endfunction

  assign row_idx = row_cnt_q[SEL_W-1:0];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    row_cnt_d   = row_cnt_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    proto_err_d = proto_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d    = base_addr;
          row_cnt_d = '0;
          k_d       = '0;
          for (int r = 0; r < ROWS; r++) acc_d[r] = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (!mem_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          if (row_cnt_q == CNT_W'(ROWS)) begin
            b_d     = mem_readdata;
            k_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            a_d[row_idx] = mem_readdata;
            row_cnt_d    = row_cnt_q + 1'b1;
            state_d      = S_REQ;
          end
        end
      end
      S_COMPUTE: begin
        for (int r = 0; r < ROWS; r++)
          acc_d[r] = acc_q[r] + mul_ext(elem(a_q[r], k_q), elem(b_q, k_q));
        k_d = k_q + 1'b1;
        if (k_q == KW'(COLS-1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any response we did not ask for is dropped and flagged.
    if (mem_readdatavalid && state_q != S_WAIT) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      row_cnt_q   <= '0;
      k_q         <= '0;
      b_q         <= '0;
      proto_err_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        a_q[r]   <= '0;
        acc_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      row_cnt_q   <= row_cnt_d;
      k_q         <= k_d;
      b_q         <= b_d;
      proto_err_q <= proto_err_d;
      for (int r = 0; r < ROWS; r++) begin
        a_q[r]   <= a_d[r];
        acc_q[r] <= acc_d[r];
      end
    end
  end

  assign mem_read    = (state_q == S_REQ);
  assign mem_address = (state_q == S_REQ) ? base_q + ADDR_W'(row_cnt_q) : '0;
  assign busy        = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_COMPUTE);
  assign done        = (state_q == S_DONE);
  assign proto_err   = proto_err_q;

  always_comb begin
    res_data = '0;
    if (32'(res_sel) < ROWS) res_data = acc_q[res_sel];
  end

endmodule

// File: tb/tb_mvm_load_engine.sv
// tb/tb_mvm_load_engine.sv - table-driven and randomized checks of mvm_load_engine
// against an arithmetic dot-product model, with unsigned and signed instances in lockstep.
module tb_mvm_load_engine;

  localparam int DW = 8, R = 8, C = 8, AW = 32, ACC = 19, WW = 64, SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] mem_address, mem_address_s;
  logic          mem_read, mem_read_s;
  logic [WW-1:0] mem_readdata;
  logic          mem_readdatavalid;
  logic          mem_waitrequest;
  logic [SW-1:0] res_sel;
  logic [ACC-1:0] res_data, res_data_s;
  logic          busy, busy_s, done, done_s, proto_err, proto_err_s;

  always #5 clk = ~clk;

  mvm_load_engine #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ADDR_W(AW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .res_sel(res_sel), .res_data(res_data), .busy(busy), .done(done), .proto_err(proto_err));

  mvm_load_engine #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ADDR_W(AW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_address(mem_address_s), .mem_read(mem_read_s), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .res_sel(res_sel), .res_data(res_data_s), .busy(busy_s), .done(done_s), .proto_err(proto_err_s));

  // Memory image: words[0..7] are matrix rows, words[8] is the vector.
  logic [WW-1:0] words [R+1];
  logic [AW-1:0] run_base = '0;
  int            stall_row = -1, stall_n = 0;
  int            stray_req = 0, stray_done = 0;
  int            exp_idx = 0, stall_cnt = 0, pend_idx = 0, addr_bad = 0;
  bit            pend = 0;

  int n_vec = 0, n_err = 0;

  // Zero-wait memory with one-cycle read latency, driven on the falling edge.
  always @(negedge clk) begin
    mem_readdatavalid = 1'b0;
    mem_waitrequest   = 1'b0;
    if (pend) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = words[pend_idx];
      pend              = 0;
    end else if (stray_req != stray_done) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = {$urandom, $urandom};
      stray_done        = stray_done + 1;
    end
    if (!busy) begin
      exp_idx   = 0;
      stall_cnt = 0;
    end else if (mem_read) begin
      if (exp_idx > R || mem_address !== run_base + AW'(exp_idx)) addr_bad = addr_bad + 1;
      if (exp_idx == stall_row && stall_cnt < stall_n) begin
        mem_waitrequest = 1'b1;
        stall_cnt       = stall_cnt + 1;
      end else begin
        pend     = 1;
        pend_idx = (exp_idx > R) ? R : exp_idx;
        exp_idx  = exp_idx + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(input logic [WW-1:0] w, input int k);
    logic [WW-1:0] t;
    t = w >> (DW*(C-1-k));
    return t[DW-1:0];
  endfunction

  function automatic logic [ACC-1:0] model(input int r, input bit sgn);
    longint s = 0;
    for (int k = 0; k < C; k++) begin
      if (sgn) s += longint'($signed(el(words[r], k))) * longint'($signed(el(words[R], k)));
      else     s += longint'(el(words[r], k)) * longint'(el(words[R], k));
    end
    return ACC'(s);
  endfunction

  task automatic do_run(input logic [AW-1:0] base, input int srow, input int sn,
                        input int pulse_at, output int lat);
    int n, bad0;
    stall_row = srow;
    stall_n   = sn;
    run_base  = base;
    bad0      = addr_bad;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("busy_done_after_start", {62'd0, busy, done}, 64'b10);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      start = (n == pulse_at);
    end
    start = 1'b0;
    lat = done ? n : -1;
    chk("addr_sequence_errors", 64'(addr_bad - bad0), 64'd0);
    chk("signed_done", {63'd0, done_s}, 64'd1);
  endtask

  task automatic check_row(input int r, input logic [ACC-1:0] eu, input logic [ACC-1:0] es);
    res_sel = SW'(r);
    #1;
    chk($sformatf("res_u[%0d]", r), 64'(res_data), 64'(eu));
    chk($sformatf("res_s[%0d]", r), 64'(res_data_s), 64'(es));
  endtask

  typedef struct {
    logic [WW-1:0]  a_word;
    logic [WW-1:0]  b_word;
    logic [AW-1:0]  base;
    int             srow;
    int             sn;
    int             pulse_at;
    logic [ACC-1:0] exp_u;
    logic [ACC-1:0] exp_s;
    int             exp_lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat, guard;
    logic [AW-1:0] b;

    tbl[0] = '{64'h0101010101010101, 64'h0102030405060708, 32'h100, -1, 0, 0, 19'd36, 19'd36, 27};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'h200, -1, 0, 0, 19'd520200, 19'd8, 27};
    tbl[2] = '{64'h8080808080808080, 64'h8080808080808080, 32'h300, -1, 0, 0, 19'd131072, 19'd131072, 27};
    tbl[3] = '{64'h0101010101010101, 64'h0102030405060708, 32'h100, 3, 5, 0, 19'd36, 19'd36, 32};
    tbl[4] = '{64'h0101010101010101, 64'h0102030405060708, 32'hFFFFFFFE, -1, 0, 0, 19'd36, 19'd36, 27};
    tbl[5] = '{64'h0101010101010101, 64'hFFFFFFFFFFFFFFFF, 32'h40, -1, 0, 20, 19'd2040, 19'd524280, 27};

    rst = 1'b1; start = 1'b0; base_addr = '0; res_sel = '0;
    mem_readdata = '0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
    for (int i = 0; i <= R; i++) words[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_proto_err", {63'd0, proto_err}, 64'd0);
    chk("reset_mem_read", {63'd0, mem_read}, 64'd0);
    chk("reset_mem_address", 64'(mem_address), 64'd0);
    chk("reset_res0", 64'(res_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table; every entry after the first starts from DONE.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < R; i++) words[i] = tbl[t].a_word;
      words[R] = tbl[t].b_word;
      do_run(tbl[t].base, tbl[t].srow, tbl[t].sn, tbl[t].pulse_at, lat);
      chk($sformatf("latency_t%0d", t), 64'(lat), 64'(tbl[t].exp_lat));
      for (int r = 0; r < R; r++) check_row(r, tbl[t].exp_u, tbl[t].exp_s);
    end

    // Reset while waiting for the row-4 response.
    b = 32'h1000;
    for (int i = 0; i <= R; i++) words[i] = {$urandom, $urandom};
    run_base = b; stall_row = -1; stall_n = 0;
    @(negedge clk); start = 1'b1; base_addr = b;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(mem_read && mem_address == b + 32'd4) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("row4_request_seen", 64'(guard < 100), 64'd1);
    @(negedge clk);
    chk("busy_in_wait_row4", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_read", {63'd0, mem_read}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_mem_address", 64'(mem_address), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_proto_err", {63'd0, proto_err}, 64'd0);
    chk("after_reset_res3", 64'(res_data), 64'd0);

    // Unsolicited response in IDLE.
    stray_req = stray_req + 1;
    repeat (2) @(negedge clk);
    chk("stray_proto_err", {63'd0, proto_err}, 64'd1);
    chk("stray_busy", {63'd0, busy}, 64'd0);
    for (int r = 0; r < R; r++) check_row(r, '0, '0);

    // Randomized runs against the dot-product model.
    for (int it = 0; it < 16; it++) begin
      int srow, sn;
      for (int i = 0; i <= R; i++) words[i] = {$urandom, $urandom};
      srow = $urandom_range(0, R);
      sn   = $urandom_range(0, 3);
      b    = $urandom;
      if (it == 0) b = 32'hFFFFFFFB;
      do_run(b, srow, sn, 0, lat);
      chk($sformatf("latency_rand%0d", it), 64'(lat), 64'(27 + sn));
      for (int r = 0; r < R; r++) check_row(r, model(r, 1'b0), model(r, 1'b1));
    end
    chk("proto_err_sticky", {63'd0, proto_err}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mvm_load_engine.md
MVM_LOAD_ENGINE -- requirements
Module: mvm_load_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-002 Parameter ROWS, default 8: matrix rows and result count; ROWS >= 2.
REQ-003 Parameter COLS, default 8: matrix columns and vector length; COLS >= 2.
REQ-004 Parameter ADDR_W, default 32: memory word-address width.
REQ-005 Parameter SIGNED, default 0: 0 selects unsigned arithmetic, 1 selects two's-complement arithmetic.
REQ-006 Derived ACC_W = 2*DATA_WIDTH + clog2(COLS); WORD_W = COLS*DATA_WIDTH; SEL_W = clog2(ROWS).
REQ-007 The module has one clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 start  in  1  one-cycle pulse that begins a load and compute run.
REQ-011 base_addr  in  ADDR_W  word address of matrix row 0; sampled on accepted start.
REQ-012 mem_address  out  ADDR_W  read address.
REQ-013 mem_read  out  1  read request.
REQ-014 mem_readdata  in  WORD_W  returned word; element k is bits [WORD_W-1-k*DATA_WIDTH -: DATA_WIDTH], so element 0 is the MSB byte.
REQ-015 mem_readdatavalid  in  1  mem_readdata is valid this cycle.
REQ-016 mem_waitrequest  in  1  memory stalls the current request.
REQ-017 res_sel  in  SEL_W  result row select.
REQ-018 res_data  out  ACC_W  combinational value of acc[res_sel]; 0 when res_sel >= ROWS.
REQ-019 busy  out  1  run in progress.
REQ-020 done  out  1  results valid; held until the next start or reset.
REQ-021 proto_err  out  1  sticky flag for an unsolicited readdatavalid.

Function
REQ-022 States: IDLE, REQ, WAIT, COMPUTE, DONE.
REQ-023 IDLE or DONE, start=1: latch base_addr, zero all ROWS accumulators and the row counter, clear done, go to REQ.
REQ-024 start in REQ, WAIT or COMPUTE is ignored.
REQ-025 REQ: mem_read=1 and mem_address = base_addr + row_cnt, with the sum wrapping modulo 2^ADDR_W; row_cnt runs 0..ROWS, where ROWS addresses the vector word.
REQ-026 REQ: mem_read and mem_address are held stable while mem_waitrequest=1; when mem_waitrequest=0 the request is accepted and the state goes to WAIT.
REQ-027 Only one request is outstanding at a time; mem_read=0 outside REQ.
REQ-028 WAIT, readdatavalid=1, row_cnt < ROWS: store the word as A[row_cnt], increment row_cnt, return to REQ.
REQ-029 WAIT, readdatavalid=1, row_cnt = ROWS: store the word as vector B and go to COMPUTE with k=0.
REQ-030 readdatavalid=1 in any state other than WAIT: the data is ignored and proto_err is set.
REQ-031 COMPUTE, each cycle: for all rows r in parallel, acc[r] += A[r][k]*B[k]; k increments; after the k=COLS-1 cycle go to DONE. Duration is exactly COLS cycles.
REQ-032 Products and sums are extended to ACC_W, sign-extended when SIGNED=1 and zero-extended otherwise. No overflow is possible.
REQ-033 DONE: done=1, busy=0, accumulators frozen.
REQ-034 busy=1 in REQ, WAIT and COMPUTE; busy=0 otherwise.
REQ-035 Minimum run latency with zero-wait memory and 1-cycle read latency: start to done = 2*(ROWS+1) + COLS + 1 cycles.

Reset
REQ-036 rst=1 forces, immediately and asynchronously: state IDLE, mem_read=0, mem_address=0, busy=0, done=0, proto_err=0, all accumulators, counters and A/B registers = 0.
REQ-037 rst asserted mid-run aborts the run; a readdatavalid arriving after reset release is treated as unsolicited (REQ-030).
REQ-038 After release, the module waits in IDLE for start.

Verification
REQ-039 Defaults; rows 0..7 = all 0x01, B = 0x0102030405060708; zero-wait memory -> each acc = 36 (0x24); done at cycle 27 after start.
REQ-040 A[r][k] = 0xFF, B = all 0xFF, SIGNED=0 -> each result = 520200 (0x7F008); SIGNED=1 with A = B = 0x80 -> 131072.
REQ-041 mem_waitrequest held high 5 cycles on row 3 -> mem_address and mem_read stay stable throughout; results unchanged; done delayed by exactly 5 cycles.
REQ-042 base_addr = 2^32-2 -> addresses issued are 0xFFFFFFFE, 0xFFFFFFFF, 0, ..., 6; results correct.
REQ-043 start pulsed during COMPUTE -> ignored; start in DONE -> done drops the next cycle and the run repeats with accumulators zeroed; stray readdatavalid in IDLE -> proto_err=1 and results unaffected.
REQ-044 rst during WAIT of row 4 -> mem_read=0 and busy=0 immediately; a new start after release yields correct results.
